// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divided-clock source and its period/duty monitor.
// The master side drives div_in; the slave (monitor) side returns measurements and status.
interface div_clk_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             div_in;
  logic             meas_vld;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] high_meas;
  logic             period_err;
  logic             duty_err;
  logic             locked;
  logic [7:0]       err_cnt;

  modport master (
    output div_in,
    input  meas_vld, period_meas, high_meas, period_err, duty_err, locked, err_cnt
  );

  modport slave (
    input  div_in,
    output meas_vld, period_meas, high_meas, period_err, duty_err, locked, err_cnt
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Self-check for an odd clock divider: measures period and sampled high time of div_in
// in clk cycles, flags out-of-range periods, duty errors and timeouts, and reports lock.
module div_clk_monitor #(
  parameter int unsigned EXP_PERIOD = 9,
  parameter int unsigned HIGH_MIN   = 4,
  parameter int unsigned HIGH_MAX   = 5,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input logic               clk,
  input logic               rst,
  div_clk_monitor_if.slave  mon
);

  localparam int unsigned RunW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] ExpPeriod = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TimeoutAt = CNT_W'(2 * EXP_PERIOD);
  localparam logic [CNT_W-1:0] HighMin   = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] HighMax   = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [RunW-1:0]  LockCount = RunW'(LOCK_COUNT);

  typedef enum logic [0:0] {StSeek, StMeas} state_e;

  state_e           state_q;
  logic             div_q, div_qq;
  logic [CNT_W-1:0] per_cnt_q, hi_cnt_q;
  logic [RunW-1:0]  good_run_q;
  logic             meas_vld_q, period_err_q, duty_err_q, locked_q;
  logic [CNT_W-1:0] period_meas_q, high_meas_q;
  logic [7:0]       err_cnt_q;

  logic             rise, per_bad, duty_bad;
  logic [7:0]       err_cnt_inc;
  logic [RunW-1:0]  good_run_inc;

  always_comb begin
    rise         = div_q & ~div_qq;
    per_bad      = (per_cnt_q != ExpPeriod);
    duty_bad     = (hi_cnt_q < HighMin) || (hi_cnt_q > HighMax);
    err_cnt_inc  = (err_cnt_q == 8'hff) ? err_cnt_q : err_cnt_q + 8'd1;
    good_run_inc = (good_run_q == LockCount) ? good_run_q : good_run_q + RunW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSeek;
      div_q         <= 1'b0;
      div_qq        <= 1'b0;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      good_run_q    <= '0;
      meas_vld_q    <= 1'b0;
      period_err_q  <= 1'b0;
      duty_err_q    <= 1'b0;
      locked_q      <= 1'b0;
      period_meas_q <= '0;
      high_meas_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      div_q        <= mon.div_in;
      div_qq       <= div_q;
      meas_vld_q   <= 1'b0;
      period_err_q <= 1'b0;
      duty_err_q   <= 1'b0;
      unique case (state_q)
        StSeek: begin
          if (rise) begin
            per_cnt_q <= CntOne;
            hi_cnt_q  <= CntOne;
            state_q   <= StMeas;
          end
        end
        StMeas: begin
          // A rise takes priority over the timeout check in the same cycle.
          if (rise) begin
            period_meas_q <= per_cnt_q;
            high_meas_q   <= hi_cnt_q;
            meas_vld_q    <= 1'b1;
            period_err_q  <= per_bad;
            duty_err_q    <= duty_bad;
            per_cnt_q     <= CntOne;
            hi_cnt_q      <= CntOne;
            if (per_bad || duty_bad) begin
              good_run_q <= '0;
              locked_q   <= 1'b0;
              err_cnt_q  <= err_cnt_inc;
            end else begin
              good_run_q <= good_run_inc;
              locked_q   <= (good_run_inc == LockCount);
            end
          end else if (per_cnt_q == TimeoutAt) begin
            period_err_q <= 1'b1;
            err_cnt_q    <= err_cnt_inc;
            good_run_q   <= '0;
            locked_q     <= 1'b0;
            state_q      <= StSeek;
          end else begin
            if (per_cnt_q != CntMax) per_cnt_q <= per_cnt_q + CntOne;
            if (div_q && (hi_cnt_q != CntMax)) hi_cnt_q <= hi_cnt_q + CntOne;
          end
        end
        default: state_q <= StSeek;
      endcase
    end
  end

  assign mon.meas_vld    = meas_vld_q;
  assign mon.period_meas = period_meas_q;
  assign mon.high_meas   = high_meas_q;
  assign mon.period_err  = period_err_q;
  assign mon.duty_err    = duty_err_q;
  assign mon.locked      = locked_q;
  assign mon.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench for div_clk_monitor: stimulus pushes expected measurement/timeout events,
// a negedge monitor pops and compares whenever the DUT pulses meas_vld/period_err/duty_err.
module tb_div_clk_monitor;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_clk_monitor_if #(.CNT_W(CNT_W)) bus ();

  div_clk_monitor #(
    .EXP_PERIOD(9),
    .HIGH_MIN  (4),
    .HIGH_MAX  (5),
    .LOCK_COUNT(4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tout;
    int per;
    int high;
    bit perr;
    bit derr;
    bit lck;
    int errc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  bit seek;
  int good_run, m_err_cnt, last_per, last_high, prev_per, prev_high;
  bit m_locked;

  function automatic void model_reset();
    seek      = 1'b1;
    good_run  = 0;
    m_err_cnt = 0;
    m_locked  = 1'b0;
    last_per  = 0;
    last_high = 0;
  endfunction

  function automatic void push_meas(int per, int high);
    exp_t e;
    e.tout = 1'b0;
    e.per  = per;
    e.high = high;
    e.perr = (per != 9);
    e.derr = (high < 4) || (high > 5);
    if (e.perr || e.derr) begin
      good_run = 0;
      m_locked = 1'b0;
      if (m_err_cnt < 255) m_err_cnt++;
    end else begin
      if (good_run < 4) good_run++;
      m_locked = (good_run == 4);
    end
    last_per  = per;
    last_high = high;
    e.lck  = m_locked;
    e.errc = m_err_cnt;
    sb.push_back(e);
  endfunction

  function automatic void push_timeout();
    exp_t e;
    e.tout = 1'b1;
    e.per  = last_per;
    e.high = last_high;
    e.perr = 1'b1;
    e.derr = 1'b0;
    good_run = 0;
    m_locked = 1'b0;
    if (m_err_cnt < 255) m_err_cnt++;
    e.lck  = 1'b0;
    e.errc = m_err_cnt;
    sb.push_back(e);
  endfunction

  task automatic drive(int per, int high);
    for (int i = 0; i < per; i++) begin
      bus.div_in = (i < high);
      @(posedge clk);
      #1;
    end
  endtask

  // One div_in period: its rise completes the previous period's measurement.
  task automatic emit(int per, int high);
    if (seek) seek = 1'b0;
    else push_meas(prev_per, prev_high);
    prev_per  = per;
    prev_high = high;
    if (per >= 19) begin
      push_timeout();
      seek = 1'b1;
    end
    drive(per, high);
  endtask

  task automatic check_zero(string name);
    tests++;
    if (bus.meas_vld !== 1'b0 || bus.period_meas !== '0 || bus.high_meas !== '0 ||
        bus.period_err !== 1'b0 || bus.duty_err !== 1'b0 || bus.locked !== 1'b0 ||
        bus.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL %s: vld=%0d per=%0d high=%0d perr=%0d derr=%0d lock=%0d errc=%0d, required all 0",
               name, bus.meas_vld, bus.period_meas, bus.high_meas, bus.period_err,
               bus.duty_err, bus.locked, bus.err_cnt);
    end
  endtask

  task automatic check_sb_empty(string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, sb.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.meas_vld || bus.period_err || bus.duty_err)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event @%0t: vld=%0d perr=%0d derr=%0d, required no event",
                 $time, bus.meas_vld, bus.period_err, bus.duty_err);
      end else begin
        e = sb.pop_front();
        if (bus.meas_vld !== !e.tout || bus.period_meas !== CNT_W'(e.per) ||
            bus.high_meas !== CNT_W'(e.high) || bus.period_err !== e.perr ||
            bus.duty_err !== e.derr || bus.locked !== e.lck || bus.err_cnt !== 8'(e.errc)) begin
          fails++;
          $display({"FAIL event @%0t: got vld=%0d per=%0d high=%0d perr=%0d derr=%0d lock=%0d ",
                    "errc=%0d, required vld=%0d per=%0d high=%0d perr=%0d derr=%0d lock=%0d errc=%0d"},
                   $time, bus.meas_vld, bus.period_meas, bus.high_meas, bus.period_err,
                   bus.duty_err, bus.locked, bus.err_cnt, !e.tout, e.per, e.high, e.perr,
                   e.derr, e.lck, e.errc);
        end
      end
    end
  end

  initial begin
    bus.div_in = 1'b0;
    rst        = 1'b1;
    model_reset();
    prev_per  = 0;
    prev_high = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    drive(3, 0);

    // Ideal divider: lock on the 5th rise
    repeat (6) emit(9, 5);
    emit(9, 4);
    // One long period, then re-lock
    emit(10, 5);
    repeat (5) emit(9, 5);
    // Duty-only error, then both errors on one edge
    emit(9, 7);
    emit(8, 2);
    repeat (5) emit(9, 5);
    // Rise exactly at 2*EXP_PERIOD is a normal (bad) measurement
    emit(18, 5);
    repeat (5) emit(9, 5);
    // div_in stuck low after lock: timeout, then re-lock after 1+4 rises
    emit(30, 5);
    repeat (5) emit(9, 5);

    // Reset 4 clks into a period
    if (seek) seek = 1'b0;
    else push_meas(prev_per, prev_high);
    drive(4, 4);
    rst        = 1'b1;
    bus.div_in = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    check_sb_empty("mid_reset_pending");
    sb.delete();
    rst = 1'b0;
    model_reset();
    drive(5, 0);
    // First rise after release must not measure
    repeat (3) emit(9, 5);

    // err_cnt saturation
    repeat (300) emit(8, 4);
    emit(9, 5);
    repeat (3) @(posedge clk);
    #1;
    check_sb_empty("final_drain");
    tests++;
    if (bus.err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL err_cnt_sat: got %0d, required 255", bus.err_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
